alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (8..64).
REQ-002 Parameter PIPE_STAGES, default 2, number of result register stages (1..4).
REQ-003 clk  input  1  single user clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  global enable; low freezes all state.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 data_in1, data_in2, data_in3  input  WIDTH each  operands.
REQ-009 ALU_func  input  4  config opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 SHL, 7 SHR, 8 SRA, 9 LT, 10 EQ, 11 SEL, 12 MAC, 13 ACCLD; 14-15 reserved.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 data_out  output  WIDTH  result of oldest in-flight operation.
REQ-013 flag_out  output  1  status bit travelling with data_out.

Function
REQ-014 Transfer occurs on in_valid&&in_ready (accept) and on out_valid&&out_ready (drain); no other event moves data.
REQ-015 Each stage holds a valid bit; a stage loads when it is empty or its contents move on in the same cycle; in_ready = en && (stage 0 empty || stage 0 advances).
REQ-016 in_ready may depend combinationally on out_ready; in_valid/out_valid shall not depend on the corresponding ready.
REQ-017 With out_ready held high, result appears on data_out exactly PIPE_STAGES cycles after accept; one accept per cycle sustained.
REQ-018 With out_ready low, data_out/flag_out/out_valid hold stable; pipeline fills up to PIPE_STAGES entries, then in_ready drops.
REQ-019 en low: no accept, no drain, no accumulator update, outputs hold; in_ready=0, out_valid held.
REQ-020 Result computed at accept and truncated to WIDTH; ADD/SUB wrap modulo 2^WIDTH; MUL returns low WIDTH bits.
REQ-021 SHL/SHR/SRA shift data_in1 by data_in2[log2(WIDTH)-1:0]; SRA sign-fills.
REQ-022 LT (signed) and EQ: data_out = zero-extended compare bit; flag_out = compare bit.
REQ-023 SEL: data_out = data_in3[0] ? data_in2 : data_in1.
REQ-024 All other ops: flag_out = (data_out == 0).
REQ-025 Reserved opcodes: data_out=0, flag_out=0, handshake unaffected.
REQ-026 ALU_func is static configuration; change while out_valid or any stage valid is undefined.

Reset
REQ-027 rst high at a clock edge clears all stage valid bits, data_out=0, flag_out=0, accumulator=0; in_ready=0 while rst high.
REQ-028 rst mid-operation discards all in-flight results; none emerge afterwards.
REQ-029 rst takes priority over en, accept and drain in the same cycle.

Configuration
REQ-030 Macro ALU_PIPE_ACC_EN compiles in a WIDTH-bit accumulator.
REQ-031 Defined: MAC on accept sets acc = acc + data_in1*data_in2 (wrap), result = new acc; ACCLD sets acc = data_in1, result = data_in1; accumulator updates only on accept.
REQ-032 Not defined: no accumulator storage; MAC and ACCLD behave as reserved opcodes (REQ-025).

Verification
REQ-033 WIDTH=32, PIPE_STAGES=2, ADD, accept 5 and 7 at cycle 0, out_ready=1 -> out_valid with data_out=12, flag_out=0 at cycle 2.
REQ-034 SUB 3-3 -> data_out=0, flag_out=1; LT 0xFFFFFFFF vs 1 -> data_out=1, flag_out=1; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-035 Stream 4 ADDs back-to-back, out_ready=0 from cycle 1 -> in_ready low after 2 entries held; data_out stable; release out_ready -> all results in order, none lost or duplicated.
REQ-036 Two ADDs in flight, rst pulsed one cycle -> out_valid=0, data_out=0 next cycle; no stale result appears later.
REQ-037 en=0 for 3 cycles with a valid result and out_ready=1 -> out_valid held, no drain; en=1 -> drains once.
REQ-038 ALU_PIPE_ACC_EN defined: ACCLD 10, MAC 2*3, MAC 4*5 -> results 10, 16, 36; undefined: same sequence -> 0, 0, 0 with flag_out=0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe; en travels with the bus.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in1;
    logic [WIDTH-1:0] data_in2;
    logic [WIDTH-1:0] data_in3;
    logic [3:0]       ALU_func;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             flag_out;

    modport master (
        output en, in_valid, data_in1, data_in2, data_in3, ALU_func, out_ready,
        input  in_ready, out_valid, data_out, flag_out
    );

    modport slave (
        input  en, in_valid, data_in1, data_in2, data_in3, ALU_func, out_ready,
        output in_ready, out_valid, data_out, flag_out
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU: result computed at accept, carried through PIPE_STAGES elastic stages.
// Define ALU_PIPE_ACC_EN to add the accumulator used by MAC/ACCLD.
module alu_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int LAST = PIPE_STAGES - 1;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_MUL   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_SRA   = 4'd8,
        OP_LT    = 4'd9,
        OP_EQ    = 4'd10,
        OP_SEL   = 4'd11,
        OP_MAC   = 4'd12,
        OP_ACCLD = 4'd13
    } alu_op_e;

    alu_op_e          w_op;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res;
    logic             w_flag;
    logic             w_known;
    logic             w_cmp_op;
    logic             w_accept;
    logic             w_unused;

    logic [WIDTH-1:0] r_data  [PIPE_STAGES];
    logic             r_flag  [PIPE_STAGES];
    logic             r_valid [PIPE_STAGES];
    logic             w_adv   [PIPE_STAGES];

`ifdef ALU_PIPE_ACC_EN
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
`endif

    assign w_op     = alu_op_e'(bus.ALU_func);
    assign w_shamt  = bus.data_in2[SHW-1:0];
    assign w_unused = &{1'b0, bus.data_in3[WIDTH-1:1]};

    always_comb begin
        w_prod   = bus.data_in1 * bus.data_in2;
        w_res    = '0;
        w_known  = 1'b1;
        w_cmp_op = 1'b0;
`ifdef ALU_PIPE_ACC_EN
        w_acc_nxt = r_acc;
`endif
        case (w_op)
            OP_ADD: w_res = bus.data_in1 + bus.data_in2;
            OP_SUB: w_res = bus.data_in1 - bus.data_in2;
            OP_AND: w_res = bus.data_in1 & bus.data_in2;
            OP_OR:  w_res = bus.data_in1 | bus.data_in2;
            OP_XOR: w_res = bus.data_in1 ^ bus.data_in2;
            OP_MUL: w_res = w_prod;
            OP_SHL: w_res = bus.data_in1 << w_shamt;
            OP_SHR: w_res = bus.data_in1 >> w_shamt;
            OP_SRA: w_res = $signed(bus.data_in1) >>> w_shamt;
            OP_LT: begin
                w_res    = {{(WIDTH-1){1'b0}}, ($signed(bus.data_in1) < $signed(bus.data_in2))};
                w_cmp_op = 1'b1;
            end
            OP_EQ: begin
                w_res    = {{(WIDTH-1){1'b0}}, (bus.data_in1 == bus.data_in2)};
                w_cmp_op = 1'b1;
            end
            OP_SEL: w_res = bus.data_in3[0] ? bus.data_in2 : bus.data_in1;
`ifdef ALU_PIPE_ACC_EN
            OP_MAC: begin
                w_acc_nxt = r_acc + w_prod;
                w_res     = w_acc_nxt;
            end
            OP_ACCLD: begin
                w_acc_nxt = bus.data_in1;
                w_res     = bus.data_in1;
            end
`endif
            default: w_known = 1'b0;
        endcase
        w_flag = w_known && (w_cmp_op ? w_res[0] : (w_res == '0));
    end

    // A stage advances when it is full and the stage after it is empty or
    // itself advancing; resolved from the output end back towards stage 0.
    always_comb begin
        logic w_chain;
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            w_adv[i] = 1'b0;
        end
        w_chain     = bus.en && r_valid[LAST] && bus.out_ready;
        w_adv[LAST] = w_chain;
        for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
            w_chain          = bus.en && r_valid[LAST-k] && (!r_valid[LAST-k+1] || w_chain);
            w_adv[LAST-k]    = w_chain;
        end
    end

    assign bus.in_ready  = !rst && bus.en && (!r_valid[0] || w_adv[0]);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_valid[LAST];
    assign bus.data_out  = r_data[LAST];
    assign bus.flag_out  = r_flag[LAST];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
                r_flag[i]  <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_valid[0] <= 1'b1;
                r_data[0]  <= w_res;
                r_flag[0]  <= w_flag;
            end else if (w_adv[0]) begin
                r_valid[0] <= 1'b0;
            end
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                if (w_adv[i-1]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= r_data[i-1];
                    r_flag[i]  <= r_flag[i-1];
                end else if (w_adv[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_PIPE_ACC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_alu_pipe;
    localparam int W = 32;
    localparam int N = 2;

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          pos;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W), .PIPE_STAGES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    ent_t        q[$];
    logic [31:0] got_d[$];
    logic        got_f[$];
    logic [31:0] acc_m;
    logic        last_accept;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] c, input logic [31:0] acc_in,
                                     output logic [31:0] r, output logic f, output logic [31:0] acc_out);
        logic [63:0] p;
        int          sa, sb;
        logic        is_cmp, is_rsv;
        p       = 64'(a) * 64'(b);
        sa      = a;
        sb      = b;
        acc_out = acc_in;
        r       = 32'd0;
        is_cmp  = 1'b0;
        is_rsv  = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = p[31:0];
            4'd6:  r = a << b[4:0];
            4'd7:  r = a >> b[4:0];
            4'd8:  r = a[31] ? ~((~a) >> b[4:0]) : (a >> b[4:0]);
            4'd9:  begin r = (sa < sb) ? 32'd1 : 32'd0; is_cmp = 1'b1; end
            4'd10: begin r = (a == b) ? 32'd1 : 32'd0; is_cmp = 1'b1; end
            4'd11: r = c[0] ? b : a;
`ifdef ALU_PIPE_ACC_EN
            4'd12: begin acc_out = acc_in + p[31:0]; r = acc_out; end
            4'd13: begin acc_out = a; r = a; end
`endif
            default: is_rsv = 1'b1;
        endcase
        f = is_rsv ? 1'b0 : (is_cmp ? r[0] : (r == 32'd0));
    endfunction

    // One clock: check outputs against the model, then advance the model
    // across the rising edge and return 1 time unit after it.
    task automatic tick();
        logic        ov, ir, acc_now;
        ent_t        e, e2;
        logic [31:0] nacc;
        int          lim;
        #1;
        ov = (q.size() > 0) && (q[0].pos == N - 1);
        ir = !rst && bus.en && ((q.size() < N) || (ov && bus.out_ready));
        chk("in_ready", 32'(bus.in_ready), 32'(ir));
        chk("out_valid", 32'(bus.out_valid), 32'(ov));
        if (ov) begin
            chk("data_out", bus.data_out, q[0].d);
            chk("flag_out", 32'(bus.flag_out), 32'(q[0].f));
        end
        if (!rst && bus.en && bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.data_out);
            got_f.push_back(bus.flag_out);
        end
        acc_now = bus.in_valid && ir;
        e.d = 32'd0; e.f = 1'b0; e.pos = 0; nacc = acc_m;
        if (acc_now) model_op(bus.ALU_func, bus.data_in1, bus.data_in2, bus.data_in3, acc_m, e.d, e.f, nacc);
        @(posedge clk);
        if (rst) begin
            q.delete();
            acc_m = 32'd0;
        end else if (bus.en) begin
            if (ov && bus.out_ready) void'(q.pop_front());
            for (int k = 0; k < q.size(); k++) begin
                lim = (k == 0) ? N - 1 : q[k-1].pos - 1;
                if (q[k].pos < lim) begin
                    e2 = q[k];
                    e2.pos = e2.pos + 1;
                    q[k] = e2;
                end
            end
            if (acc_now) begin
                q.push_back(e);
                acc_m = nacc;
            end
        end
        last_accept = acc_now;
        #1;
    endtask

    task automatic drain_all();
        bus.in_valid  = 1'b0;
        bus.en        = 1'b1;
        bus.out_ready = 1'b1;
        rst           = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("drain_idle", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic one_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] exp_d, input logic exp_f);
        bus.ALU_func  = op;
        bus.data_in1  = a;
        bus.data_in2  = b;
        bus.data_in3  = c;
        bus.en        = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"}, bus.data_out, exp_d);
        chk({tag, "_flag"}, 32'(bus.flag_out), 32'(exp_f));
        drain_all();
    endtask

    initial begin
        int          idx, base;
        logic [31:0] e0, e1, e2;

        rst = 1'b1;
        bus.en = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ALU_func = 4'd0;
        bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0;
        acc_m = 32'd0; last_accept = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst_flag_out", 32'(bus.flag_out), 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        one_op("add_5_7", 4'd0, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0);
        one_op("sub_3_3", 4'd1, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1);
        one_op("lt_neg", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b1);
        one_op("sra_4", 4'd8, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1'b0);
        one_op("eq_ne", 4'd10, 32'd9, 32'd8, 32'd0, 32'd0, 1'b0);
        one_op("sel_1", 4'd11, 32'd1, 32'd2, 32'd1, 32'd2, 1'b0);
        one_op("mul_wrap", 4'd5, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'h0001_0000, 1'b0);
        one_op("rsv_14", 4'd14, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0);

`ifdef ALU_PIPE_ACC_EN
        e0 = 32'd10; e1 = 32'd16; e2 = 32'd36;
`else
        e0 = 32'd0; e1 = 32'd0; e2 = 32'd0;
`endif
        one_op("accld_10", 4'd13, 32'd10, 32'd0, 32'd0, e0, 1'b0);
        one_op("mac_2_3", 4'd12, 32'd2, 32'd3, 32'd0, e1, 1'b0);
        one_op("mac_4_5", 4'd12, 32'd4, 32'd5, 32'd0, e2, 1'b0);

        // Back-pressure: 4 ADDs, consumer stalls after the first cycle.
        bus.ALU_func = 4'd0; bus.en = 1'b1; bus.out_ready = 1'b1;
        base = got_d.size();
        idx = 0;
        bus.in_valid = 1'b1; bus.data_in1 = 32'd1; bus.data_in2 = 32'd0;
        tick();
        if (last_accept) idx++;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.data_in1 = 32'(idx * 100 + 1); bus.data_in2 = 32'(idx);
            tick();
            if (last_accept) idx++;
        end
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_data", bus.data_out, 32'd1);
        chk("bp_accepted", 32'(idx), 32'd2);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 4; c++) begin
            bus.data_in1 = 32'(idx * 100 + 1); bus.data_in2 = 32'(idx);
            tick();
            if (last_accept) idx++;
        end
        drain_all();
        chk("bp_drained", 32'(got_d.size() - base), 32'd4);
        if (got_d.size() - base == 4) begin
            chk("bp_order0", got_d[base], 32'd1);
            chk("bp_order3", got_d[base+3], 32'd304);
        end

        // Reset with two results in flight.
        base = got_d.size();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.data_in1 = 32'd20; bus.data_in2 = 32'd22;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_data", bus.data_out, 32'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("rst_no_stale", 32'(got_d.size() - base), 32'd0);

        // Enable low freezes a ready result.
        bus.in_valid = 1'b1; bus.data_in1 = 32'd3; bus.data_in2 = 32'd4;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        base = got_d.size();
        bus.out_ready = 1'b1; bus.en = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("en_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("en_hold_data", bus.data_out, 32'd7);
        chk("en_no_drain", 32'(got_d.size() - base), 32'd0);
        bus.en = 1'b1;
        tick();
        chk("en_drain_once", 32'(got_d.size() - base), 32'd1);
        chk("en_after_valid", 32'(bus.out_valid), 32'd0);

        // Randomized traffic per opcode, pipeline emptied between opcodes.
        for (int op = 0; op < 16; op++) begin
            bus.ALU_func = 4'(op);
            for (int n = 0; n < 30; n++) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = ($urandom_range(0, 9) < 7);
                bus.en        = ($urandom_range(0, 9) < 8);
                rst           = ($urandom_range(0, 49) == 0);
                bus.data_in1  = $urandom();
                bus.data_in2  = ($urandom_range(0, 3) == 0) ? bus.data_in1 : $urandom();
                bus.data_in3  = $urandom();
                tick();
            end
            drain_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
